// File: rtl/alu_pkg.sv
// Shared execute-stage constants: alu_ctrl encodings and divider state type.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_pkg;

  // alu_ctrl encodings shared by the alu and div_unit.
  // Encodings 1100-1111 belong to the divider.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;
  localparam logic [3:0] ALU_DIV  = 4'b1100;
  localparam logic [3:0] ALU_DIVU = 4'b1101;
  localparam logic [3:0] ALU_REM  = 4'b1110;
  localparam logic [3:0] ALU_REMU = 4'b1111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and div_unit.
// Latency: n/a (wiring only).
// Backpressure: none; busy tells the hazard unit to hold the request stable.
// Ports: start/alu_op1/alu_op2/alu_ctrl/flush from the pipeline,
//        busy/valid/div_out back from the divider.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [3:0]       alu_ctrl;
  logic             flush;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] div_out;

  modport master (
    output start, alu_op1, alu_op2, alu_ctrl, flush,
    input  busy, valid, div_out
  );

  modport slave (
    input  start, alu_op1, alu_op2, alu_ctrl, flush,
    output busy, valid, div_out
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit (radix-2 restoring, one quotient bit per cycle).
// Latency: valid WIDTH+1 cycles after the accepting edge; divide-by-zero and signed overflow in 1.
// Backpressure: none; busy (registered) stalls the pipeline, flush aborts, start ignored while busy.
// Ports: clk, rst_n (async, active low); bus (slave) carries start, alu_op1 (dividend),
//        alu_op2 (divisor), alu_ctrl, flush in and busy, valid, div_out out.
module div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;       // running remainder (always < divisor)
  logic [WIDTH-1:0] quo_q, quo_d;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;     // divisor magnitude
  logic             rem_sel_q, rem_sel_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] div_out_q, div_out_d;

  logic             accept;
  logic             is_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;            // WIDTH+1-bit partial remainder
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] res_quo, res_rem;
  logic             busy_o, valid_o;

  // Operand conditioning for a new request.
  always_comb begin
    is_signed = ~bus.alu_ctrl[0];
    a_neg     = is_signed & bus.alu_op1[WIDTH-1];
    b_neg     = is_signed & bus.alu_op2[WIDTH-1];
    a_mag     = a_neg ? -bus.alu_op1 : bus.alu_op1;
    b_mag     = b_neg ? -bus.alu_op2 : bus.alu_op2;
  end

  // One restoring step: shift in the next dividend bit, keep the difference
  // only when it did not go negative (sign bit of the WIDTH+1-bit result).
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
    if (diff[WIDTH]) begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end else begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end
    // Sign correction applied to the final step's outputs.
    res_quo = neg_quo_q ? -quo_step : quo_step;
    res_rem = neg_rem_q ? -rem_step : rem_step;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    rem_sel_d = rem_sel_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div_out_d = div_out_q;
    busy_o    = (state_q == DIV_CALC);
    valid_o   = (state_q == DIV_DONE);

    accept = bus.start && !bus.flush && (state_q != DIV_CALC) &&
             (bus.alu_ctrl inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU});

    if (bus.flush) begin
      // Abort from any state; div_out keeps its last result.
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE, DIV_DONE: begin
          state_d = DIV_IDLE;
          if (accept) begin
            rem_sel_d = bus.alu_ctrl[1];
            if (bus.alu_op2 == '0) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              div_out_d = bus.alu_ctrl[1] ? bus.alu_op1 : '1;
              state_d   = DIV_DONE;
            end else if (is_signed && (bus.alu_op1 == MOST_NEG) && (bus.alu_op2 == '1)) begin
              // Signed overflow: quotient wraps to the most negative value.
              div_out_d = bus.alu_ctrl[1] ? '0 : MOST_NEG;
              state_d   = DIV_DONE;
            end else begin
              quo_d     = a_mag;
              rem_d     = '0;
              dvsr_d    = b_mag;
              cnt_d     = CNT_W'(WIDTH - 1);
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              state_d   = DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            div_out_d = rem_sel_q ? res_rem : res_quo;
            state_d   = DIV_DONE;
          end
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      rem_sel_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div_out_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      rem_sel_q <= rem_sel_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div_out_q <= div_out_d;
    end
  end

  assign bus.busy    = busy_o;
  assign bus.valid   = valid_o;
  assign bus.div_out = div_out_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with a cycle-level reference model and a per-cycle compare.
// Latency: n/a.
// Backpressure: n/a.
module tb_div_unit;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  div_unit_if #(.WIDTH(32)) dif ();

  div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of an RV32M divide op.
  function automatic bit is_special(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [3:0] op);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [1:0] kind;
    sa = a;
    sb = b;
    kind = op[1:0];
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (kind)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // Reference timing: a normal op spends 32 cycles busy, then one valid cycle.
  int          m_left;
  logic        m_valid;
  logic [31:0] m_out;
  logic [31:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_out   <= 32'd0;
      m_pend  <= 32'd0;
    end else if (dif.flush) begin
      m_left  <= 0;
      m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left  <= m_left - 1;
      m_valid <= (m_left == 1);
      if (m_left == 1) m_out <= m_pend;
    end else if (dif.start && dif.alu_ctrl[3:2] == 2'b11) begin
      if (is_special(dif.alu_op1, dif.alu_op2, dif.alu_ctrl)) begin
        m_valid <= 1'b1;
        m_out   <= ref_result(dif.alu_op1, dif.alu_op2, dif.alu_ctrl);
      end else begin
        m_valid <= 1'b0;
        m_left  <= 32;
        m_pend  <= ref_result(dif.alu_op1, dif.alu_op2, dif.alu_ctrl);
      end
    end else begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_busy", {31'd0, dif.busy}, {31'd0, (m_left > 0)});
      check("cyc_valid", {31'd0, dif.valid}, {31'd0, m_valid});
      check("cyc_div_out", dif.div_out, m_out);
    end
  end

  // Issue one request and wait for its valid pulse; b2b issues in the current (DONE) cycle.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [31:0] exp, input int lat, input bit b2b);
    int k;
    bit got;
    if (!b2b) @(negedge clk);
    dif.start    = 1'b1;
    dif.alu_op1  = a;
    dif.alu_op2  = b;
    dif.alu_ctrl = op;
    @(posedge clk);
    #1;
    dif.start    = 1'b0;
    // Operand churn while the divide runs must not matter.
    dif.alu_op1  = $urandom;
    dif.alu_op2  = $urandom;
    dif.alu_ctrl = 4'b1100 | 4'($urandom_range(0, 3));
    k = 0;
    got = 0;
    while (!got && k < 60) begin
      @(negedge clk);
      k++;
      if (dif.valid) got = 1;
    end
    check({nm, "_lat"}, k, lat);
    check({nm, "_val"}, dif.div_out, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int vcnt;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    dif.start    = 1'b0;
    dif.flush    = 1'b0;
    dif.alu_op1  = 32'd0;
    dif.alu_op2  = 32'd0;
    dif.alu_ctrl = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, dif.busy}, 32'd0);
    check("rst_valid", {31'd0, dif.valid}, 32'd0);
    check("rst_div_out", dif.div_out, 32'd0);
    rst_n = 1'b1;

    run_op("divu_100_7", 32'd100, 32'd7, 4'b1101, 32'd14, 33, 0);
    run_op("remu_100_7", 32'd100, 32'd7, 4'b1111, 32'd2, 33, 0);
    run_op("div_m100_7", 32'hFFFF_FF9C, 32'd7, 4'b1100, 32'hFFFF_FFF2, 33, 0);
    run_op("rem_m100_7", 32'hFFFF_FF9C, 32'd7, 4'b1110, 32'hFFFF_FFFE, 33, 0);
    run_op("div_100_m7", 32'd100, 32'hFFFF_FFF9, 4'b1100, 32'hFFFF_FFF2, 33, 0);
    run_op("rem_100_m7", 32'd100, 32'hFFFF_FFF9, 4'b1110, 32'd2, 33, 0);
    run_op("divu_big", 32'hFFFF_FFFF, 32'h10, 4'b1101, 32'h0FFF_FFFF, 33, 0);
    run_op("divu_5_0", 32'd5, 32'd0, 4'b1101, 32'hFFFF_FFFF, 1, 0);
    run_op("remu_5_0", 32'd5, 32'd0, 4'b1111, 32'd5, 1, 0);
    run_op("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'b1100, 32'h8000_0000, 1, 0);
    run_op("rem_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 4'b1110, 32'd0, 1, 0);
    run_op("divu_ovfpat", 32'h8000_0000, 32'hFFFF_FFFF, 4'b1101, 32'd0, 33, 0);

    // Flush in the 10th CALC cycle.
    @(negedge clk);
    dif.start    = 1'b1;
    dif.alu_op1  = 32'd1000;
    dif.alu_op2  = 32'd3;
    dif.alu_ctrl = 4'b1101;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (10) @(negedge clk);
    dif.flush = 1'b1;
    @(negedge clk);
    dif.flush = 1'b0;
    check("flush_busy", {31'd0, dif.busy}, 32'd0);
    check("flush_div_out", dif.div_out, 32'd0);
    vcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.valid) vcnt++;
    end
    check("flush_no_valid", vcnt, 0);
    run_op("divu_9_3", 32'd9, 32'd3, 4'b1101, 32'd3, 33, 0);

    // Non-divide encoding is ignored.
    @(negedge clk);
    dif.start    = 1'b1;
    dif.alu_op1  = 32'd50;
    dif.alu_op2  = 32'd5;
    dif.alu_ctrl = 4'b0000;
    @(posedge clk);
    #1 dif.start = 1'b0;
    @(negedge clk);
    check("ign_busy", {31'd0, dif.busy}, 32'd0);
    check("ign_valid", {31'd0, dif.valid}, 32'd0);

    // Back-to-back: second request issued in the DONE cycle of the first.
    run_op("b2b_a", 32'd81, 32'd9, 4'b1101, 32'd9, 33, 0);
    run_op("b2b_b", 32'd1000, 32'd33, 4'b1111, 32'd10, 33, 1);
    run_op("b2b_c", 32'd7, 32'd0, 4'b1100, 32'hFFFF_FFFF, 1, 1);

    // Reset in the 20th CALC cycle.
    @(negedge clk);
    dif.start    = 1'b1;
    dif.alu_op1  = 32'd77;
    dif.alu_op2  = 32'd5;
    dif.alu_ctrl = 4'b1101;
    @(posedge clk);
    #1 dif.start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, dif.busy}, 32'd0);
    check("arst_valid", {31'd0, dif.valid}, 32'd0);
    check("arst_div_out", dif.div_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 32'd77, 32'd5, 4'b1101, 32'd15, 33, 0);
    run_op("post_rst_rem", 32'hFFFF_FFB3, 32'd5, 4'b1110, 32'hFFFF_FFFE, 33, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
